// File: rtl/sa_edge_feeder.sv
// Edge feeder for an output-stationary systolic array: sequences one tile
// (clear, feed K operand beats, drain the wavefront) and skews A/B lanes onto the array edges.
module sa_edge_feeder #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ELEM_BITS = 8,
  parameter int KLEN_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [KLEN_BITS-1:0]      k_len,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [ROWS*ELEM_BITS-1:0] a_vec,
  input  logic [COLS*ELEM_BITS-1:0] b_vec,
  output logic [ROWS*ELEM_BITS-1:0] a_edge,
  output logic [ROWS-1:0]           a_v_edge,
  output logic [COLS*ELEM_BITS-1:0] b_edge,
  output logic [COLS-1:0]           b_v_edge,
  output logic                      pe_clr,
  output logic                      pe_shift_en,
  output logic                      busy,
  output logic                      done
);

  // IDLE wait for start | CLR clear PEs | FEED accept beats | DRAIN flush wavefront
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLR   = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int                DRN_W    = $clog2(ROWS + COLS);
  localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(ROWS + COLS - 2);

  logic [1:0]           state_q, state_d;
  logic [KLEN_BITS-1:0] kcnt_q, kcnt_d;
  logic [DRN_W-1:0]     dcnt_q, dcnt_d;
  logic                 done_q, done_d;
  logic                 accept;

  assign vec_ready   = (state_q == S_FEED);
  assign pe_clr      = (state_q == S_CLR);
  assign pe_shift_en = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign accept      = vec_valid && vec_ready;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kcnt_d  = k_len;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        dcnt_d  = DRN_LOAD;
        state_d = (kcnt_q != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        if (accept) begin
          kcnt_d = kcnt_q - KLEN_BITS'(1);
          if (kcnt_q == KLEN_BITS'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // ROWS+COLS-1 cycles: the counter runs DRN_LOAD down to 0 inclusive
        if (dcnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q - DRN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
    end
  end

  // Lane r gets r+1 stages so the wavefront reaches PE(r,c) at the same time from both sides.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_line
    logic [ELEM_BITS-1:0] dat_q [r+1];
    logic [r:0]           vld_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int s = 0; s <= r; s++) begin
          dat_q[s] <= '0;
        end
        vld_q <= '0;
      end else if (pe_shift_en) begin
        dat_q[0] <= accept ? a_vec[r*ELEM_BITS +: ELEM_BITS] : '0;
        vld_q[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign a_edge[r*ELEM_BITS +: ELEM_BITS] = dat_q[r];
    assign a_v_edge[r]                      = vld_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_line
    logic [ELEM_BITS-1:0] dat_q [c+1];
    logic [c:0]           vld_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int s = 0; s <= c; s++) begin
          dat_q[s] <= '0;
        end
        vld_q <= '0;
      end else if (pe_shift_en) begin
        dat_q[0] <= accept ? b_vec[c*ELEM_BITS +: ELEM_BITS] : '0;
        vld_q[0] <= accept;
        for (int s = 1; s <= c; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign b_edge[c*ELEM_BITS +: ELEM_BITS] = dat_q[c];
    assign b_v_edge[c]                      = vld_q[c];
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Bench for sa_edge_feeder: directed tile sequence with random operands, an attached 4x4 PE array
// model, and a time-stamped beat history that predicts every edge lane each cycle.
module tb_sa_edge_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int EB   = 8;
  localparam int KB   = 16;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start;
  logic [KB-1:0]        k_len;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [ROWS*EB-1:0]   a_vec;
  logic [COLS*EB-1:0]   b_vec;
  logic [ROWS*EB-1:0]   a_edge;
  logic [ROWS-1:0]      a_v_edge;
  logic [COLS*EB-1:0]   b_edge;
  logic [COLS-1:0]      b_v_edge;
  logic                 pe_clr;
  logic                 pe_shift_en;
  logic                 busy;
  logic                 done;

  sa_edge_feeder #(.ROWS(ROWS), .COLS(COLS), .ELEM_BITS(EB), .KLEN_BITS(KB)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .a_vec(a_vec), .b_vec(b_vec),
    .a_edge(a_edge), .a_v_edge(a_v_edge), .b_edge(b_edge), .b_v_edge(b_v_edge),
    .pe_clr(pe_clr), .pe_shift_en(pe_shift_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // beat history keyed by accept cycle, plus the tile's operands in order
  logic [31:0] hist_a [int];
  logic [31:0] hist_b [int];
  logic [31:0] ta [$];
  logic [31:0] tb [$];
  logic [31:0] src_a [16];
  logic [31:0] src_b [16];

  int n_acc = 0, n_ready = 0, n_clr = 0, n_done = 0, last_clr = -1;

  // attached output-stationary PE array model
  int acc [ROWS][COLS];
  int pa  [ROWS][COLS], pb  [ROWS][COLS], na  [ROWS][COLS], nb  [ROWS][COLS];
  bit pav [ROWS][COLS], pbv [ROWS][COLS], nav [ROWS][COLS], nbv [ROWS][COLS];
  int ad, bd;
  bit av, bv;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_lane(input bit is_a, input int c, input int lane);
    logic [31:0] w;
    if (is_a) begin
      if (!hist_a.exists(c)) return 9'd0;
      w = hist_a[c];
    end else begin
      if (!hist_b.exists(c)) return 9'd0;
      w = hist_b[c];
    end
    return {1'b1, w[lane*EB +: EB]};
  endfunction

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      hist_a.delete();
      hist_b.delete();
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          pa[i][j] = 0; pb[i][j] = 0; pav[i][j] = 1'b0; pbv[i][j] = 1'b0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        check($sformatf("a_edge[%0d] cyc %0d", r, cyc), {a_v_edge[r], a_edge[r*EB +: EB]},
              exp_lane(1'b1, cyc - 1 - r, r));
      for (int c = 0; c < COLS; c++)
        check($sformatf("b_edge[%0d] cyc %0d", c, cyc), {b_v_edge[c], b_edge[c*EB +: EB]},
              exp_lane(1'b0, cyc - 1 - c, c));
      if (vec_valid && vec_ready) begin
        hist_a[cyc] = a_vec;
        hist_b[cyc] = b_vec;
        n_acc++;
      end
      if (vec_ready) n_ready++;
      if (done) n_done++;
      if (pe_clr) begin
        n_clr++;
        last_clr = cyc;
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++) acc[i][j] = 0;
      end
      if (pe_shift_en) begin
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++) begin
            if (j == 0) begin
              ad = int'($signed(a_edge[i*EB +: EB])); av = a_v_edge[i];
            end else begin
              ad = pa[i][j-1]; av = pav[i][j-1];
            end
            if (i == 0) begin
              bd = int'($signed(b_edge[j*EB +: EB])); bv = b_v_edge[j];
            end else begin
              bd = pb[i-1][j]; bv = pbv[i-1][j];
            end
            if (av && bv) acc[i][j] += ad * bd;
            na[i][j] = ad; nav[i][j] = av; nb[i][j] = bd; nbv[i][j] = bv;
          end
        pa = na; pav = nav; pb = nb; pbv = nbv;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!vec_valid) begin
      a_vec = $urandom;
      b_vec = $urandom;
    end
    if (!start) k_len = KB'($urandom);
  endtask

  task automatic start_tile(input int k);
    start = 1'b1;
    k_len = KB'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input int gap, output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    repeat (gap) tick();
    a_vec = a; b_vec = b; vec_valid = 1'b1;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      if (vec_ready === 1'b1) begin
        got   = 1'b1;
        t_acc = cyc;
        ta.push_back(a);
        tb.push_back(b);
      end
      @(posedge clk);
      #1;
    end
    vec_valid = 1'b0;
    a_vec = $urandom;
    b_vec = $urandom;
    check("beat_accepted", got, 1);
  endtask

  task automatic wait_done(output int t_done);
    t_done = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t_done = cyc;
        break;
      end
    end
    check("done_seen", t_done >= 0, 1);
  endtask

  // expected accumulators: plain matrix product over the tile's accepted beats
  task automatic check_tile();
    logic [31:0] wa, wb;
    int e;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        e = 0;
        for (int k = 0; k < ta.size(); k++) begin
          wa = ta[k];
          wb = tb[k];
          e += int'($signed(wa[i*EB +: EB])) * int'($signed(wb[j*EB +: EB]));
        end
        check($sformatf("acc[%0d][%0d]", i, j), acc[i][j], e);
      end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++) begin
      src_a[k] = $urandom;
      src_b[k] = $urandom;
    end
  endtask

  task automatic run_tile(input int k, input int gap, input bit rgap);
    int t, td, d0, g;
    ta.delete(); tb.delete();
    d0 = n_done;
    t  = -1;
    start_tile(k);
    for (int b = 0; b < k; b++) begin
      g = rgap ? int'($urandom_range(0, gap)) : gap;
      send_beat(src_a[b], src_b[b], g, t);
    end
    wait_done(td);
    if (k > 0) check("done_latency_after_last_beat", td - t, 8);
    else       check("done_latency_after_clr", td - last_clr, 8);
    check_tile();
    @(posedge clk);
    #1;
    check("done_pulse_count", n_done - d0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, td, d0, a0, c0, r0;
    rstn = 1'b0; start = 1'b0; vec_valid = 1'b0; k_len = '0;
    a_vec = $urandom; b_vec = $urandom;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) acc[i][j] = 0;

    // reset state
    tick(); tick();
    @(negedge clk);
    check("reset_a_edge", {a_v_edge, a_edge}, 0);
    check("reset_b_edge", {b_v_edge, b_edge}, 0);
    check("reset_ctrl", {vec_ready, pe_clr, pe_shift_en, busy, done}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // single beat, lanes {1,2,3,4} x {5,6,7,8}
    ta.delete(); tb.delete();
    d0 = n_done;
    start_tile(1);
    @(negedge clk);
    check("clr_ctrl", {busy, pe_clr, pe_shift_en, vec_ready}, 4'b1100);
    @(posedge clk); #1;
    send_beat(32'h04030201, 32'h08070605, 0, t);
    @(negedge clk);
    check("a0_at_T1", {a_v_edge[0], a_edge[7:0]}, 9'h101);
    check("b0_at_T1", {b_v_edge[0], b_edge[7:0]}, 9'h105);
    check("drain_ctrl", {busy, pe_clr, pe_shift_en, vec_ready}, 4'b1010);
    repeat (3) @(negedge clk);
    check("a3_at_T4", {a_v_edge[3], a_edge[31:24]}, 9'h104);
    check("b3_at_T4", {b_v_edge[3], b_edge[31:24]}, 9'h108);
    wait_done(td);
    check("single_done_latency", td - t, 8);
    check("pe33_single", acc[3][3], 32);
    check("pe00_single", acc[0][0], 5);
    check_tile();
    @(negedge clk);
    check("done_then_idle", {done, busy, vec_ready}, 3'b000);
    check("single_done_count", n_done - d0, 1);
    @(posedge clk); #1;

    // bubbles: same data with 2-cycle gaps, then gap-free
    fill_random();
    a0 = n_acc;
    run_tile(3, 2, 1'b0);
    check("bubble_beats", n_acc - a0, 3);
    run_tile(3, 0, 1'b0);

    // zero length
    c0 = n_clr; r0 = n_ready;
    run_tile(0, 0, 1'b0);
    check("zero_clr_cycles", n_clr - c0, 1);
    check("zero_ready_cycles", n_ready - r0, 0);

    // start during FEED must not relatch k_len
    fill_random();
    ta.delete(); tb.delete();
    a0 = n_acc; d0 = n_done;
    start_tile(2);
    send_beat(src_a[0], src_b[0], 0, t);
    start = 1'b1; k_len = KB'(9);
    tick();
    start = 1'b0;
    send_beat(src_a[1], src_b[1], 0, t);
    wait_done(td);
    check("ignored_start_done_latency", td - t, 8);
    check_tile();
    @(posedge clk); #1;
    vec_valid = 1'b1;
    repeat (10) tick();
    vec_valid = 1'b0;
    @(negedge clk);
    check("ignored_start_beats", n_acc - a0, 2);
    check("ignored_start_done_count", n_done - d0, 1);
    check("ignored_start_idle", busy, 0);
    @(posedge clk); #1;

    // random tiles with random gaps
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_tile(int'($urandom_range(1, 7)), 2, 1'b1);
    end

    // identity x B(1..16), twice back-to-back
    for (int k = 0; k < 4; k++) begin
      src_a[k] = 32'h1 << (8 * k);
      src_b[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    end
    for (int rep = 0; rep < 2; rep++) begin
      run_tile(4, 0, 1'b0);
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          check($sformatf("ident_c[%0d][%0d] rep %0d", i, j, rep), acc[i][j], 4*i + j + 1);
    end

    // reset in the middle of FEED
    fill_random();
    ta.delete(); tb.delete();
    start_tile(5);
    send_beat(src_a[0], src_b[0], 0, t);
    send_beat(src_a[1], src_b[1], 0, t);
    d0 = n_done;
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check("midreset_a_edge", {a_v_edge, a_edge}, 0);
    check("midreset_b_edge", {b_v_edge, b_edge}, 0);
    check("midreset_ctrl", {vec_ready, pe_clr, pe_shift_en, busy, done}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ta.delete(); tb.delete();
    start_tile(1);
    @(negedge clk);
    check("post_reset_clr", {busy, pe_clr}, 2'b11);
    @(posedge clk); #1;
    send_beat(src_a[2], src_b[2], 0, t);
    wait_done(td);
    check("post_reset_done_latency", td - t, 8);
    check_tile();
    @(posedge clk); #1;
    check("post_reset_done_count", n_done - d0, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
